// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter encoding,
// BTB entry layout and the tag extraction helper.
package bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Wide enough for the smallest legal table (4 entries -> 28 tag bits).
    localparam int BP_TAG_W = 28;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    // Upper PC bits above the index, zero-extended into the fixed tag field.
    function automatic logic [BP_TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
        logic [31:0] shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[BP_TAG_W-1:0];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic; never wraps at either end.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next_ctr
);

    // Step toward the observed outcome, clamping at strong-T / strong-NT.
    always_comb begin
        next_ctr = ctr;
        if (taken) begin
            if (ctr == CTR_ST) begin
                next_ctr = CTR_ST;
            end else begin
                next_ctr = ctr + 2'd1;
            end
        end else begin
            if (ctr == CTR_SNT) begin
                next_ctr = CTR_SNT;
            end else begin
                next_ctr = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, trained from the EX resolution bus.
// Optional global-history indexing of the counters under BP_GSHARE_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_nextpc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        stall
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t          btb_r [ENTRIES];
    logic [1:0]          ctr_r [ENTRIES];

    logic [IDX_W-1:0]    fetch_idx_s;
    logic [IDX_W-1:0]    fetch_ctr_idx_s;
    logic [BP_TAG_W-1:0] fetch_tag_s;
    logic                fetch_hit_s;

    logic [IDX_W-1:0]    upd_idx_s;
    logic [IDX_W-1:0]    upd_ctr_idx_s;
    logic [BP_TAG_W-1:0] upd_tag_s;
    logic                upd_hit_s;
    logic [1:0]          upd_next_ctr_s;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0]    ghr_r;
    logic                unused_s;
    assign unused_s = ^{fetch_pc[1:0], update_pc[1:0]};
`else
    logic                unused_s;
    assign unused_s = ^{fetch_pc[1:0], update_pc[1:0], stall};
`endif

    // Lookup for the fetch PC; reads only registered state, so no bypass.
    always_comb begin
        fetch_idx_s = fetch_pc[IDX_W+1:2];
        fetch_tag_s = pc_tag(fetch_pc, IDX_W);
`ifdef BP_GSHARE_EN
        fetch_ctr_idx_s = fetch_idx_s ^ ghr_r;
`else
        fetch_ctr_idx_s = fetch_idx_s;
`endif
        fetch_hit_s = btb_r[fetch_idx_s].valid && (btb_r[fetch_idx_s].tag == fetch_tag_s);
        pred_taken  = fetch_hit_s && ctr_r[fetch_ctr_idx_s][1];
        if (pred_taken) begin
            pred_nextpc = btb_r[fetch_idx_s].target;
        end else begin
            pred_nextpc = fetch_pc + 32'd4;
        end
    end

    // Lookup for the resolving instruction, using pre-shift history.
    always_comb begin
        upd_idx_s = update_pc[IDX_W+1:2];
        upd_tag_s = pc_tag(update_pc, IDX_W);
`ifdef BP_GSHARE_EN
        upd_ctr_idx_s = upd_idx_s ^ ghr_r;
`else
        upd_ctr_idx_s = upd_idx_s;
`endif
        upd_hit_s = btb_r[upd_idx_s].valid && (btb_r[upd_idx_s].tag == upd_tag_s);
    end

    bp_sat_counter u_sat_counter (
        .ctr      (ctr_r[upd_ctr_idx_s]),
        .taken    (update_taken),
        .next_ctr (upd_next_ctr_s)
    );

    // Table training; reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i].valid <= 1'b0;
                ctr_r[i]       <= CTR_RESET;
            end
        end else if (update_en) begin
            if (upd_hit_s) begin
                ctr_r[upd_ctr_idx_s] <= upd_next_ctr_s;
                if (update_taken) begin
                    btb_r[upd_idx_s].target <= update_target;
                end
            end else if (update_taken) begin
                btb_r[upd_idx_s]     <= '{valid: 1'b1, tag: upd_tag_s, target: update_target};
                ctr_r[upd_ctr_idx_s] <= CTR_WT;
            end
        end
    end

`ifdef BP_GSHARE_EN
    // Non-speculative global history, shifted at resolve time unless stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (update_en && !stall) begin
            if (IDX_W > 1) begin
                ghr_r <= {ghr_r[IDX_W-2:0], update_taken};
            end else begin
                ghr_r <= update_taken;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, no gshare).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_nextpc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        stall;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_nextpc   (pred_nextpc),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        update_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        step();
        update_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFC};
        logic [31:0] exp [3] = '{32'h0000_0104, 32'h0000_0004, 32'h0000_0000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_pc = pcs[i];
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0 || pred_nextpc !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_pred[%0d]: got taken=%b next=%h, want taken=0 next=%h",
                         i, pred_taken, pred_nextpc, exp[i]);
            end
        end
    endtask

    task automatic test_train();
        logic [31:0] pcs [4] = '{32'h0000_0100, 32'h0000_0102, 32'h0000_0104, 32'h0000_1100};
        logic        etk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp [4] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0108, 32'h0000_1104};
        do_reset();
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 4; i++) begin
            fetch_pc = pcs[i];
            #1;
            n_cmp++;
            if (pred_taken !== etk[i] || pred_nextpc !== exp[i]) begin
                n_fail++;
                $display("FAIL train_pred[%0d]: got taken=%b next=%h, want taken=%b next=%h",
                         i, pred_taken, pred_nextpc, etk[i], exp[i]);
            end
        end
    endtask

    // Walk the counter 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10.
    task automatic test_counter();
        logic tk  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic etk [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp;
        do_reset();
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        fetch_pc = 32'h0000_0100;
        for (int i = 0; i < 8; i++) begin
            do_update(32'h0000_0100, tk[i], 32'h0000_0200);
            exp = etk[i] ? 32'h0000_0200 : 32'h0000_0104;
            n_cmp++;
            if (pred_taken !== etk[i] || pred_nextpc !== exp) begin
                n_fail++;
                $display("FAIL counter_step[%0d]: got taken=%b next=%h, want taken=%b next=%h",
                         i, pred_taken, pred_nextpc, etk[i], exp);
            end
        end
        // Taken update on a hit retargets; not-taken must leave target alone.
        do_update(32'h0000_0100, 1'b1, 32'h0000_0280);
        do_update(32'h0000_0100, 1'b0, 32'h0000_0999);
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_nextpc !== 32'h0000_0280) begin
            n_fail++;
            $display("FAIL counter_retarget: got taken=%b next=%h, want taken=1 next=00000280",
                     pred_taken, pred_nextpc);
        end
    endtask

    task automatic test_alias();
        do_reset();
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        do_update(32'h0000_0200, 1'b1, 32'h0000_0300);
        fetch_pc = 32'h0000_0100;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_nextpc !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL alias_old: got taken=%b next=%h, want taken=0 next=00000104",
                     pred_taken, pred_nextpc);
        end
        fetch_pc = 32'h0000_0200;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_nextpc !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL alias_new: got taken=%b next=%h, want taken=1 next=00000300",
                     pred_taken, pred_nextpc);
        end
        // Not-taken miss must not allocate, nor disturb the resident entry.
        do_update(32'h0000_0500, 1'b0, 32'h0000_0700);
        do_update(32'h0000_0100, 1'b0, 32'h0000_0700);
        fetch_pc = 32'h0000_0200;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_nextpc !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL alias_nt_miss: got taken=%b next=%h, want taken=1 next=00000300",
                     pred_taken, pred_nextpc);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        fetch_pc      = 32'h0000_0100;
        update_en     = 1'b1;
        update_pc     = 32'h0000_0100;
        update_taken  = 1'b1;
        update_target = 32'h0000_0200;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_nextpc !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL same_cycle_old: got taken=%b next=%h, want taken=0 next=00000104",
                     pred_taken, pred_nextpc);
        end
        step();
        update_en = 1'b0;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_nextpc !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL same_cycle_new: got taken=%b next=%h, want taken=1 next=00000200",
                     pred_taken, pred_nextpc);
        end
    endtask

    task automatic test_hold_and_stall();
        do_reset();
        // update_en low with live data must not write.
        update_en     = 1'b0;
        update_pc     = 32'h0000_0140;
        update_taken  = 1'b1;
        update_target = 32'h0000_0AA0;
        step();
        fetch_pc = 32'h0000_0140;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_nextpc !== 32'h0000_0144) begin
            n_fail++;
            $display("FAIL hold_no_en: got taken=%b next=%h, want taken=0 next=00000144",
                     pred_taken, pred_nextpc);
        end
        // Stall suppresses only history; the table write still lands.
        stall = 1'b1;
        do_update(32'h0000_0140, 1'b1, 32'h0000_0AA0);
        stall = 1'b0;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_nextpc !== 32'h0000_0AA0) begin
            n_fail++;
            $display("FAIL stall_write: got taken=%b next=%h, want taken=1 next=00000aa0",
                     pred_taken, pred_nextpc);
        end
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        rst           = 1'b1;
        update_en     = 1'b1;
        update_pc     = 32'h0000_0180;
        update_taken  = 1'b1;
        update_target = 32'h0000_0400;
        step();
        rst       = 1'b0;
        update_en = 1'b0;
        fetch_pc = 32'h0000_0100;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_nextpc !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL rst_mid_old: got taken=%b next=%h, want taken=0 next=00000104",
                     pred_taken, pred_nextpc);
        end
        fetch_pc = 32'h0000_0180;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_nextpc !== 32'h0000_0184) begin
            n_fail++;
            $display("FAIL rst_mid_new: got taken=%b next=%h, want taken=0 next=00000184",
                     pred_taken, pred_nextpc);
        end
    endtask

    initial begin
        rst           = 1'b1;
        fetch_pc      = 32'h0000_0000;
        update_en     = 1'b0;
        update_pc     = 32'h0000_0000;
        update_taken  = 1'b0;
        update_target = 32'h0000_0000;
        stall         = 1'b0;
        test_reset();
        test_train();
        test_counter();
        test_alias();
        test_same_cycle();
        test_hold_and_stall();
        test_reset_mid_update();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
